// File: rtl/mult_pkg.sv
// Shared types and constants for the signed/unsigned sequential multiplier.
// Also provides the sizing helper for the iteration counter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Counter must hold values 0..width, so it needs clog2(width+1) bits.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/signed_seq_multiplier_abs_unit.sv
// Combinational magnitude extraction: returns |value| as an unsigned WIDTH-bit
// number plus the sign bit, treating value as unsigned when signed_mode is 0.
module abs_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  // The most-negative value negates to itself, which read as unsigned is the exact magnitude.
  assign sign      = signed_mode & value[WIDTH-1];
  assign magnitude = sign ? (-value) : value;

endmodule

// File: rtl/signed_seq_multiplier.sv
// Sequential shift-add multiplier with runtime signed/unsigned mode, valid/ready
// handshakes on both sides, and two's-complement plus sign/magnitude results.
module signed_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   magnitude,
  output logic                 negative,
  output logic                 busy
);

  localparam int CW = count_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("signed_seq_multiplier: WIDTH out of range");
  end

  state_t state, state_next;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [CW-1:0]      count;
  logic               neg_flag;
  logic [WIDTH:0]     sum;
  logic               fix_neg;

  abs_unit #(.WIDTH(WIDTH)) u_abs_a (
    .value       (a),
    .signed_mode (signed_mode),
    .magnitude   (mag_a),
    .sign        (sign_a)
  );

  abs_unit #(.WIDTH(WIDTH)) u_abs_b (
    .value       (b),
    .signed_mode (signed_mode),
    .magnitude   (mag_b),
    .sign        (sign_b)
  );

  // Upper half plus optional multiplicand, one extra bit to keep the carry.
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign fix_neg = neg_flag & (|acc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (EARLY_OUT && ((mag_a == '0) || (mag_b == '0))) state_next = FIX;
          else                                               state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change in FIX, so they persist until the next operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      neg_flag  <= 1'b0;
      product   <= '0;
      magnitude <= '0;
      negative  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc      <= '0;
            mcand    <= mag_b;
            mplier   <= mag_a;
            count    <= '0;
            neg_flag <= sign_a ^ sign_b;
          end
        end
        RUN: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        FIX: begin
          magnitude <= acc;
          negative  <= fix_neg;
          product   <= fix_neg ? (-acc) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule
